// File: rtl/jtag_ocimem_ctrl.sv
// Sysclk-side JTAG debug memory controller: runs wrapper ocimem commands against a
// 2**ADDR_W x 32 debug RAM that is also shared with a lower-priority Avalon-MM CPU slave.
module jtag_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              ld_done_q, ld_done_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              any_strobe, jtag_we, cpu_we, cpu_wait;
  logic              unused_jdo;
  logic [31:0]       mem [0:(2**ADDR_W)-1];

  assign jdo_addr   = jdo[17 +: ADDR_W];
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    op_addr_d  = op_addr_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;
    error_d    = error_q;
    ld_done_d  = 1'b0;
    cpu_pend_d = 1'b0;
    ram_raddr  = avs_address;
    jtag_we    = 1'b0;
    cpu_we     = 1'b0;
    cpu_wait   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_b) begin
          op_addr_d = mon_a_q;
          wdata_d   = jdo[34:3];
          mon_a_d   = mon_a_q + 1'b1;
          ready_d   = 1'b0;
          state_d   = WR;
        end else if (take_action_ocimem_a) begin
          ready_d = 1'b0;
          if (jdo[34]) begin
            mon_a_d   = jdo_addr;
            op_addr_d = jdo_addr;
            if (jdo[33]) error_d = 1'b0;
            // A bare address load has no RAM phase; it reports done one cycle later.
            if (jdo[35]) state_d = RD_WAIT;
            else         ld_done_d = 1'b1;
          end else begin
            op_addr_d = mon_a_q;
            mon_a_d   = mon_a_q + 1'b1;
            state_d   = RD_WAIT;
          end
        end else if (take_no_action_ocimem_a) begin
          op_addr_d = mon_a_q;
          ready_d   = 1'b0;
          state_d   = RD_WAIT;
        end else begin
          if (ld_done_q) ready_d = 1'b1;
          // CPU read: grant cycle issues the RAM read, the following cycle returns it.
          if (cpu_pend_q) begin
            cpu_wait = 1'b0;
          end else if (avs_write) begin
            cpu_wait = 1'b0;
            cpu_we   = !reset;
          end else if (avs_read) begin
            cpu_pend_d = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        ram_raddr = op_addr_q;
        state_d   = RD_CAP;
      end
      RD_CAP: begin
        mon_d_d = rdata_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      WR: begin
        jtag_we = !reset;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && any_strobe) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      op_addr_q  <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      ld_done_q  <= 1'b0;
      cpu_pend_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      op_addr_q  <= op_addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      ld_done_q  <= ld_done_d;
      cpu_pend_q <= cpu_pend_d;
      rdata_q    <= mem[ram_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (jtag_we)     mem[op_addr_q]   <= wdata_q;
    else if (cpu_we) mem[avs_address] <= avs_writedata;
  end

  assign MonDReg         = mon_d_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;
  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = reset | cpu_wait;

endmodule
